// File: rtl/vblank_update_scheduler.sv
// rtl/vblank_update_scheduler.sv - vertical timing and vblank-only round-robin update-slot arbiter
// Optional overrun tracking is enabled by defining VSCHED_OVERRUN_EN.
module vblank_update_scheduler #(
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int NREQ      = 3,
  parameter int MAX_SLOT  = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            h_tick,
  input  logic [NREQ-1:0] req,
  output logic            v_sync,
  output logic            v_video,
  output logic [9:0]      row,
  output logic            frame_start,
  output logic            vblank_start,
  output logic [NREQ-1:0] grant,
  output logic            overrun
);

  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW      = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, gidx, pick;
  logic [SW-1:0]   slot_cnt;
  logic            found, start, rel, voluntary, abort, last_line, vblank, slot_max;

  assign last_line = (row == 10'(V_TOTAL - 1));
  assign vblank    = (row >= 10'(V_VISIBLE));
  assign v_video   = ~vblank;
  assign v_sync    = ~((row >= 10'(V_VISIBLE + V_FRONT)) && (row < 10'(V_VISIBLE + V_FRONT + V_SYNC)));

  assign slot_max  = (slot_cnt == SW'(MAX_SLOT - 1));
  assign abort     = h_tick && last_line;
  assign voluntary = ~req[gidx] || slot_max;
  assign rel       = (state == GRANT) && (voluntary || abort);
  // No grant may start on the final blank line, so visible row 0 is never shared with a grant.
  assign start     = (state == IDLE) && vblank && ~last_line && found;

  assign grant = (state == GRANT) ? ({{(NREQ-1){1'b0}}, 1'b1} << gidx) : '0;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[(int'(rr_ptr) + i) % NREQ]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GRANT;
      GRANT:   if (rel) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      row          <= '0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      rr_ptr       <= '0;
      gidx         <= '0;
      slot_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      frame_start  <= h_tick && last_line;
      vblank_start <= h_tick && (row == 10'(V_VISIBLE - 1));
      if (h_tick) row <= last_line ? '0 : row + 10'd1;
      if (start) begin
        gidx     <= pick;
        slot_cnt <= '0;
      end else if (state == GRANT && !slot_max) begin
        slot_cnt <= slot_cnt + SW'(1);
      end
      if (rel) rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
    end
  end

`ifdef VSCHED_OVERRUN_EN
  logic [NREQ-1:0] served;

  // served collects every requester granted since the last frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      served  <= '0;
      overrun <= 1'b0;
    end else begin
      if (rel && !voluntary) overrun <= 1'b1;
      if (frame_start) begin
        if ((req & ~served) != '0) overrun <= 1'b1;
        served <= '0;
      end else begin
        served <= served | grant;
      end
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// tb/tb_vblank_update_scheduler.sv - directed table and sequence checks for vblank_update_scheduler
module tb_vblank_update_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       h_tick;
  logic [2:0] req;
  logic       v_sync, v_video, frame_start, vblank_start, overrun;
  logic [9:0] row;
  logic [2:0] grant;

  int checks = 0;
  int failures = 0;
  int r = 0;
  int fs_cnt = 0, vs_cnt = 0, inv_bad = 0;
  int zeros, len;
  logic exp_ovr;

  typedef struct {
    int   row;
    logic vs;
    logic vv;
  } dvec_t;
  dvec_t tbl[9];

  vblank_update_scheduler dut (
    .clk(clk), .reset(reset), .h_tick(h_tick), .req(req),
    .v_sync(v_sync), .v_video(v_video), .row(row),
    .frame_start(frame_start), .vblank_start(vblank_start),
    .grant(grant), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    fs_cnt += int'(frame_start);
    vs_cnt += int'(vblank_start);
    if ((grant & (grant - 3'd1)) != 3'd0) inv_bad++;
    if (grant != 3'd0 && v_video) inv_bad++;
  endtask

  task automatic htick();
    h_tick = 1'b1;
    cyc();
    h_tick = 1'b0;
    r = (r + 1) % 525;
  endtask

  task automatic advance_to(input int target, input int gap);
    while (r != target) begin
      htick();
      repeat (gap) cyc();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1,   1'b1, 1'b1};
    tbl[1] = '{479, 1'b1, 1'b1};
    tbl[2] = '{480, 1'b1, 1'b0};
    tbl[3] = '{489, 1'b1, 1'b0};
    tbl[4] = '{490, 1'b0, 1'b0};
    tbl[5] = '{491, 1'b0, 1'b0};
    tbl[6] = '{492, 1'b1, 1'b0};
    tbl[7] = '{524, 1'b1, 1'b0};
    tbl[8] = '{0,   1'b1, 1'b1};
`ifdef VSCHED_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif

    reset = 1'b1; h_tick = 1'b0; req = 3'b000;
    cyc(); cyc();
    check("reset_row", row, 0);
    check("reset_vsync", v_sync, 1);
    check("reset_vvideo", v_video, 1);
    check("reset_frame_start", frame_start, 0);
    check("reset_vblank_start", vblank_start, 0);
    check("reset_grant", grant, 0);
    check("reset_overrun", overrun, 0);
    reset = 1'b0;
    cyc();

    // full frame sweep
    fs_cnt = 0; vs_cnt = 0;
    for (int n = 0; n < 525; n++) begin
      htick();
      check("sweep_row", row, r);
      check("sweep_vsync", v_sync, (r >= 490 && r < 492) ? 0 : 1);
      check("sweep_vvideo", v_video, (r < 480) ? 1 : 0);
      cyc();
    end
    check("sweep_frame_start_count", fs_cnt, 1);
    check("sweep_vblank_start_count", vs_cnt, 1);
    check("sweep_wrap_row", row, 0);

    // decode table
    for (int i = 0; i < 9; i++) begin
      advance_to(tbl[i].row, 1);
      check("tbl_row", row, tbl[i].row);
      check("tbl_vsync", v_sync, tbl[i].vs);
      check("tbl_vvideo", v_video, tbl[i].vv);
    end

    // round robin with 5-cycle holds
    advance_to(479, 1);
    req = 3'b111;
    htick();
    check("rr_vblank_start", vblank_start, 1);
    check("rr_grant_at_vblank_start", grant, 0);
    for (int k = 0; k < 3; k++) begin
      zeros = 0;
      while (grant == 3'd0 && zeros < 20) begin zeros++; cyc(); end
      check("rr_zero_cycles", zeros, (k == 0) ? 1 : 2);
      check("rr_grant_order", grant, 1 << k);
      len = 0;
      while (grant == 3'(1 << k) && len < 100) begin
        len++;
        if (len == 5) req[k] = 1'b0;
        cyc();
      end
      check("rr_grant_len", len, 5);
    end
    cyc(); cyc();
    check("rr_idle_after", grant, 0);

    // next frame restarts at requester 0, then 64-cycle timeout for sole requester 1
    advance_to(479, 1);
    req = 3'b111;
    htick();
    cyc();
    check("frame2_first_grant", grant, 3'b001);
    req = 3'b000;
    cyc();
    check("frame2_release", grant, 0);
    cyc();
    req = 3'b010;
    cyc();
    len = 0;
    while (grant == 3'b010 && len < 200) begin len++; cyc(); end
    check("timeout_len", len, 64);
    zeros = 0;
    while (grant == 3'd0 && zeros < 20) begin zeros++; cyc(); end
    check("timeout_gap", zeros, 2);
    check("timeout_regrant", grant, 3'b010);
    req = 3'b000;
    cyc(); cyc();
    check("timeout_idle", grant, 0);

    // request raised mid-frame waits for vblank
    advance_to(100, 1);
    req = 3'b100;
    advance_to(479, 1);
    check("late_req_visible_grant", grant, 0);
    htick();
    check("late_req_vblank_start", vblank_start, 1);
    check("late_req_grant_at_vbs", grant, 0);
    cyc();
    check("late_req_grant", grant, 3'b100);
    req = 3'b000;
    cyc(); cyc();

    // abort at end of frame
    advance_to(523, 1);
    req = 3'b001;
    cyc();
    check("abort_grant_on", grant, 3'b001);
    repeat (5) cyc();
    htick();
    check("abort_row524_grant", grant, 3'b001);
    repeat (5) cyc();
    htick();
    check("abort_row", row, 0);
    check("abort_grant_off", grant, 0);
    check("abort_frame_start", frame_start, 1);
    check("abort_vvideo", v_video, 1);
    check("abort_overrun", overrun, exp_ovr);
    req = 3'b000;
    cyc();

    // reset mid-grant at row 500
    advance_to(500, 1);
    req = 3'b001;
    cyc(); cyc();
    check("rst_mid_grant_on", grant, 3'b001);
    reset = 1'b1;
    cyc();
    check("rst_mid_grant", grant, 0);
    check("rst_mid_row", row, 0);
    check("rst_mid_vvideo", v_video, 1);
    check("rst_mid_vsync", v_sync, 1);
    check("rst_mid_overrun", overrun, 0);
    reset = 1'b0; req = 3'b000; r = 0;
    cyc();

    check("invariants", inv_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
